hit_resolver: RTL and testbench

//  Frame-synchronous collision and scoring engine: N_SHOTS bullets against N_DUCKS ducks.

---
 rtl/ducks_pkg.sv | 27 ++
 rtl/hit_box_check.sv | 40 ++++
 rtl/hit_resolver.sv | 214 +++++++++++++++++++++
 tb/tb_hit_resolver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ducks_pkg.sv
// Shared definitions for the duck/bullet collision engine.
// Holds coordinate widths, default sprite sizes, the scan FSM encoding
// and a helper for sizing the pair-index counters.
package ducks_pkg;

   localparam int unsigned X_W   = 11;  // signed duck x
   localparam int unsigned Y_W   = 10;  // unsigned y (ducks and shots)
   localparam int unsigned SX_W  = 10;  // unsigned shot x
   localparam int unsigned CMP_W = 12;  // signed compare width, no wrap for off-screen ducks

   localparam int unsigned DEF_DUCK_W = 64;
   localparam int unsigned DEF_DUCK_H = 48;
   localparam int unsigned DEF_SHOT_W = 4;
   localparam int unsigned DEF_SHOT_H = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Index width for a counter over n entries; never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hit_box_check.sv
// Combinational axis-aligned bounding-box overlap test for one duck/shot pair.
// Ports:
//   dx, dy     duck top-left corner (dx signed, may be off-screen left)
//   sx, sy     shot top-left corner (unsigned)
//   overlap_c  boxes overlap; boxes that only touch at an edge do not overlap
module hit_box_check
   import ducks_pkg::*;
#(
   parameter int unsigned DUCK_W = DEF_DUCK_W,
   parameter int unsigned DUCK_H = DEF_DUCK_H,
   parameter int unsigned SHOT_W = DEF_SHOT_W,
   parameter int unsigned SHOT_H = DEF_SHOT_H
) (
   input  logic signed [X_W-1:0]  dx,
   input  logic        [Y_W-1:0]  dy,
   input  logic        [SX_W-1:0] sx,
   input  logic        [Y_W-1:0]  sy,
   output logic                   overlap_c
);

   localparam logic signed [CMP_W-1:0] BOX_DW = CMP_W'(DUCK_W);
   localparam logic signed [CMP_W-1:0] BOX_DH = CMP_W'(DUCK_H);
   localparam logic signed [CMP_W-1:0] BOX_SW = CMP_W'(SHOT_W);
   localparam logic signed [CMP_W-1:0] BOX_SH = CMP_W'(SHOT_H);

   logic signed [CMP_W-1:0] dx_e;
   logic signed [CMP_W-1:0] dy_e;
   logic signed [CMP_W-1:0] sx_e;
   logic signed [CMP_W-1:0] sy_e;

   // Duck x sign-extends so a negative position stays left of the screen.
   assign dx_e = {{(CMP_W-X_W){dx[X_W-1]}}, dx};
   assign dy_e = {{(CMP_W-Y_W){1'b0}}, dy};
   assign sx_e = {{(CMP_W-SX_W){1'b0}}, sx};
   assign sy_e = {{(CMP_W-Y_W){1'b0}}, sy};

   assign overlap_c = (sx_e + BOX_SW > dx_e) && (sx_e < dx_e + BOX_DW) &&
                      (sy_e + BOX_SH > dy_e) && (sy_e < dy_e + BOX_DH);

endmodule

// File: rtl/hit_resolver.sv
// Frame-synchronous collision and scoring engine. On frame_start the duck and
// shot positions are snapshotted, then every (duck, shot) pair is tested one per
// cycle through a single shared box checker; the resulting masks are published
// as one-cycle pulses together with done, and the score is advanced.
// Ports:
//   vga_clk, reset       pixel clock, asynchronous active-high reset
//   frame_start          start-of-vblank pulse, launches a scan when idle
//   duck_x/y, duck_alive packed per-duck position (x signed) and hittable flag
//   shot_x/y, shot_valid packed per-shot position and in-flight flag
//   duck_hit, shot_kill  one-cycle hit / retire pulses
//   score                saturating running score
//   busy                 scan in progress
//   done                 one-cycle pulse with the hit/kill pulses
//   overrun              sticky, frame_start seen while a scan was running
module hit_resolver
   import ducks_pkg::*;
#(
   parameter int unsigned N_DUCKS = 4,
   parameter int unsigned N_SHOTS = 8,
   parameter int unsigned DUCK_W  = DEF_DUCK_W,
   parameter int unsigned DUCK_H  = DEF_DUCK_H,
   parameter int unsigned SHOT_W  = DEF_SHOT_W,
   parameter int unsigned SHOT_H  = DEF_SHOT_H,
   parameter int unsigned SCORE_W = 10,
   parameter int unsigned POINTS  = 1
) (
   input  logic                      vga_clk,
   input  logic                      reset,
   input  logic                      frame_start,
   input  logic [N_DUCKS*X_W-1:0]    duck_x,
   input  logic [N_DUCKS*Y_W-1:0]    duck_y,
   input  logic [N_DUCKS-1:0]        duck_alive,
   input  logic [N_SHOTS*SX_W-1:0]   shot_x,
   input  logic [N_SHOTS*Y_W-1:0]    shot_y,
   input  logic [N_SHOTS-1:0]        shot_valid,
   output logic [N_DUCKS-1:0]        duck_hit,
   output logic [N_SHOTS-1:0]        shot_kill,
   output logic [SCORE_W-1:0]        score,
   output logic                      busy,
   output logic                      done,
   output logic                      overrun
);

   localparam int unsigned DI_W  = clog2_min1(N_DUCKS);
   localparam int unsigned SI_W  = clog2_min1(N_SHOTS);
   localparam int unsigned SUM_W = SCORE_W + 4;
   localparam logic [SUM_W-1:0] SCORE_MAX = {4'b0, {SCORE_W{1'b1}}};

   state_t state, state_n;
   logic [DI_W-1:0] d_idx, d_n;
   logic [SI_W-1:0] s_idx, s_n;
   logic [N_DUCKS-1:0] hit_mask, hit_n;
   logic [N_SHOTS-1:0] kill_mask, kill_n;
   logic [N_DUCKS-1:0] duck_hit_n;
   logic [N_SHOTS-1:0] shot_kill_n;
   logic [SCORE_W-1:0] score_n, score_sat;
   logic busy_n, done_n, overrun_n, snap;

   // Input snapshot, frozen for the duration of a scan
   logic signed [X_W-1:0]  dx_q [N_DUCKS];
   logic        [Y_W-1:0]  dy_q [N_DUCKS];
   logic        [SX_W-1:0] sx_q [N_SHOTS];
   logic        [Y_W-1:0]  sy_q [N_SHOTS];
   logic [N_DUCKS-1:0] alive_q;
   logic [N_SHOTS-1:0] valid_q;

   logic overlap_c;
   logic pair_hit;
   logic [SUM_W-1:0] pop, sum;

   // Shared pair checker, fed by the current scan indices
   hit_box_check #(
      .DUCK_W (DUCK_W),
      .DUCK_H (DUCK_H),
      .SHOT_W (SHOT_W),
      .SHOT_H (SHOT_H)
   ) u_box (
      .dx        (dx_q[d_idx]),
      .dy        (dy_q[d_idx]),
      .sx        (sx_q[s_idx]),
      .sy        (sy_q[s_idx]),
      .overlap_c (overlap_c)
   );

   // Masks make earlier (lower-index) pairs win arbitration
   assign pair_hit = alive_q[d_idx] & valid_q[s_idx] &
                     ~hit_mask[d_idx] & ~kill_mask[s_idx] & overlap_c;

   // Score increment with saturation, evaluated in a widened sum
   always_comb begin
      pop = '0;
      for (int i = 0; i < N_DUCKS; i++) begin
         pop = pop + SUM_W'(hit_mask[i]);
      end
      sum       = SUM_W'(score) + SUM_W'(POINTS) * pop;
      score_sat = (sum > SCORE_MAX) ? {SCORE_W{1'b1}} : SCORE_W'(sum);
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      d_n         = d_idx;
      s_n         = s_idx;
      hit_n       = hit_mask;
      kill_n      = kill_mask;
      snap        = 1'b0;
      duck_hit_n  = '0;
      shot_kill_n = '0;
      done_n      = 1'b0;
      score_n     = score;
      overrun_n   = overrun;

      if (frame_start && (state != IDLE)) begin
         overrun_n = 1'b1;
      end

      case (state)
         IDLE: begin
            if (frame_start) begin
               snap    = 1'b1;
               hit_n   = '0;
               kill_n  = '0;
               d_n     = '0;
               s_n     = '0;
               state_n = SCAN;
            end
         end
         SCAN: begin
            if (pair_hit) begin
               hit_n[d_idx]  = 1'b1;
               kill_n[s_idx] = 1'b1;
            end
            if (s_idx == SI_W'(N_SHOTS - 1)) begin
               s_n = '0;
               if (d_idx == DI_W'(N_DUCKS - 1)) begin
                  d_n     = '0;
                  state_n = COMMIT;
               end else begin
                  d_n = d_idx + DI_W'(1);
               end
            end else begin
               s_n = s_idx + SI_W'(1);
            end
         end
         COMMIT: begin
            duck_hit_n  = hit_mask;
            shot_kill_n = kill_mask;
            done_n      = 1'b1;
            score_n     = score_sat;
            state_n     = IDLE;
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

   // State, scan and output registers
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         d_idx     <= '0;
         s_idx     <= '0;
         hit_mask  <= '0;
         kill_mask <= '0;
         duck_hit  <= '0;
         shot_kill <= '0;
         score     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         d_idx     <= d_n;
         s_idx     <= s_n;
         hit_mask  <= hit_n;
         kill_mask <= kill_n;
         duck_hit  <= duck_hit_n;
         shot_kill <= shot_kill_n;
         score     <= score_n;
         busy      <= busy_n;
         done      <= done_n;
         overrun   <= overrun_n;
      end
   end

   // Snapshot registers, loaded only when a scan is launched
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_DUCKS; i++) begin
            dx_q[i] <= '0;
            dy_q[i] <= '0;
         end
         for (int i = 0; i < N_SHOTS; i++) begin
            sx_q[i] <= '0;
            sy_q[i] <= '0;
         end
         alive_q <= '0;
         valid_q <= '0;
      end else if (snap) begin
         for (int i = 0; i < N_DUCKS; i++) begin
            dx_q[i] <= duck_x[i*X_W +: X_W];
            dy_q[i] <= duck_y[i*Y_W +: Y_W];
         end
         for (int i = 0; i < N_SHOTS; i++) begin
            sx_q[i] <= shot_x[i*SX_W +: SX_W];
            sy_q[i] <= shot_y[i*Y_W +: Y_W];
         end
         alive_q <= duck_alive;
         valid_q <= shot_valid;
      end
   end

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: reset, hit detection, arbitration, edge
// cases, overrun, saturation (SCORE_W=4 instance) and snapshot behaviour.
module tb_hit_resolver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, reset_sat, frame_start, frame_start_sat;
   logic [43:0] duck_x;
   logic [39:0] duck_y;
   logic [3:0]  duck_alive;
   logic [79:0] shot_x;
   logic [79:0] shot_y;
   logic [7:0]  shot_valid;

   logic [3:0] duck_hit, duck_hit_s;
   logic [7:0] shot_kill, shot_kill_s;
   logic [9:0] score;
   logic [3:0] score_s;
   logic busy, done, overrun, busy_s, done_s, overrun_s;

   int n_cmp = 0;
   int n_err = 0;
   int exp_score = 0;

   hit_resolver dut (
      .vga_clk (clk), .reset (reset), .frame_start (frame_start),
      .duck_x (duck_x), .duck_y (duck_y), .duck_alive (duck_alive),
      .shot_x (shot_x), .shot_y (shot_y), .shot_valid (shot_valid),
      .duck_hit (duck_hit), .shot_kill (shot_kill), .score (score),
      .busy (busy), .done (done), .overrun (overrun)
   );

   hit_resolver #(.SCORE_W(4)) dut_sat (
      .vga_clk (clk), .reset (reset_sat), .frame_start (frame_start_sat),
      .duck_x (duck_x), .duck_y (duck_y), .duck_alive (duck_alive),
      .shot_x (shot_x), .shot_y (shot_y), .shot_valid (shot_valid),
      .duck_hit (duck_hit_s), .shot_kill (shot_kill_s), .score (score_s),
      .busy (busy_s), .done (done_s), .overrun (overrun_s)
   );

   task automatic clear_inputs();
      duck_x = '0; duck_y = '0; duck_alive = '0;
      shot_x = '0; shot_y = '0; shot_valid = '0;
   endtask

   task automatic set_duck(input int d, input int x, input int y, input bit a);
      duck_x[d*11 +: 11] = 11'(x);
      duck_y[d*10 +: 10] = 10'(y);
      duck_alive[d]      = a;
   endtask

   task automatic set_shot(input int s, input int x, input int y, input bit v);
      shot_x[s*10 +: 10] = 10'(x);
      shot_y[s*10 +: 10] = 10'(y);
      shot_valid[s]      = v;
   endtask

   // Returns just after the sampling edge of frame_start
   task automatic start_frame();
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
   endtask

   task automatic start_frame_sat();
      @(posedge clk); #1 frame_start_sat = 1'b1;
      @(posedge clk); #1 frame_start_sat = 1'b0;
   endtask

   // Edges until done is seen; -1 if the budget expires
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (done) begin lat = i; break; end
      end
   endtask

   task automatic wait_done_sat(output int lat);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (done_s) begin lat = i; break; end
      end
   endtask

   task automatic test_reset();
      int pulses;
      reset = 1'b1;
      repeat (2) @(posedge clk); #1;
      n_cmp++; if ({duck_hit, shot_kill} !== 12'h000) begin n_err++; $display("FAIL reset_masks: got %h want 000", {duck_hit, shot_kill}); end
      n_cmp++; if (score !== 10'd0) begin n_err++; $display("FAIL reset_score: got %0d want 0", score); end
      n_cmp++; if ({busy, done, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy, done, overrun}); end
      reset = 1'b0;
      // Reset in the middle of a scan that would have scored
      clear_inputs();
      set_duck(0, 100, 50, 1'b1);
      set_shot(3, 120, 60, 1'b1);
      start_frame();
      repeat (9) @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midscan_busy: got %b want 1", busy); end
      reset = 1'b1; #1;
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL async_reset: got %b want 00", {busy, done}); end
      @(posedge clk); #1 reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL reset_discard: got %0d active cycles want 0", pulses); end
      n_cmp++; if (score !== 10'd0) begin n_err++; $display("FAIL reset_discard_score: got %0d want 0", score); end
      exp_score = 0;
   endtask

   task automatic test_single_hit();
      int lat;
      clear_inputs();
      set_duck(0, 100, 50, 1'b1);
      set_shot(3, 120, 60, 1'b1);
      start_frame();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
      wait_done(lat);
      exp_score += 1;
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL single_latency: got %0d want 33", lat); end
      n_cmp++; if (duck_hit !== 4'b0001) begin n_err++; $display("FAIL single_duck_hit: got %b want 0001", duck_hit); end
      n_cmp++; if (shot_kill !== 8'h08) begin n_err++; $display("FAIL single_shot_kill: got %h want 08", shot_kill); end
      n_cmp++; if (score !== 10'(exp_score)) begin n_err++; $display("FAIL single_score: got %0d want %0d", score, exp_score); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy); end
      @(posedge clk); #1;
      n_cmp++; if ({done, duck_hit, shot_kill} !== 13'h0) begin n_err++; $display("FAIL single_pulse_width: got %h want 0", {done, duck_hit, shot_kill}); end
   endtask

   task automatic test_arbitration();
      int lat;
      // Two ducks, one shot: lower duck takes it
      clear_inputs();
      set_duck(1, 200, 100, 1'b1);
      set_duck(2, 210, 100, 1'b1);
      set_shot(0, 220, 120, 1'b1);
      start_frame(); wait_done(lat);
      exp_score += 1;
      n_cmp++; if ({duck_hit, shot_kill} !== {4'b0010, 8'h01}) begin n_err++; $display("FAIL arb_two_ducks: got %b/%h want 0010/01", duck_hit, shot_kill); end
      n_cmp++; if (score !== 10'(exp_score)) begin n_err++; $display("FAIL arb_two_ducks_score: got %0d want %0d", score, exp_score); end
      // One duck, two shots: lower shot retires, duck hit once
      clear_inputs();
      set_duck(0, 300, 200, 1'b1);
      set_shot(1, 310, 210, 1'b1);
      set_shot(2, 320, 220, 1'b1);
      start_frame(); wait_done(lat);
      exp_score += 1;
      n_cmp++; if ({duck_hit, shot_kill} !== {4'b0001, 8'h02}) begin n_err++; $display("FAIL arb_two_shots: got %b/%h want 0001/02", duck_hit, shot_kill); end
      // Two ducks, two shots, all overlapping: paired off in index order
      clear_inputs();
      set_duck(0, 500, 300, 1'b1);
      set_duck(1, 500, 300, 1'b1);
      set_shot(0, 510, 310, 1'b1);
      set_shot(1, 520, 320, 1'b1);
      start_frame(); wait_done(lat);
      exp_score += 2;
      n_cmp++; if ({duck_hit, shot_kill} !== {4'b0011, 8'h03}) begin n_err++; $display("FAIL arb_pairs: got %b/%h want 0011/03", duck_hit, shot_kill); end
      n_cmp++; if (score !== 10'(exp_score)) begin n_err++; $display("FAIL arb_pairs_score: got %0d want %0d", score, exp_score); end
   endtask

   task automatic test_boundaries();
      int lat;
      clear_inputs();
      set_duck(0, -30, 100, 1'b1);   // spans -30..34: shot at 20 hits
      set_shot(0, 20, 110, 1'b1);
      set_duck(1, -100, 200, 1'b1);  // spans -100..-36: shot at 0 misses
      set_shot(1, 0, 210, 1'b1);
      set_duck(2, 40, 300, 1'b1);    // shot right edge touches duck left edge
      set_shot(2, 36, 310, 1'b1);
      set_duck(3, 40, 400, 1'b1);    // shot3 touches right edge, shot4 overlaps by one
      set_shot(3, 104, 410, 1'b1);
      set_shot(4, 103, 410, 1'b1);
      start_frame(); wait_done(lat);
      exp_score += 2;
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL bound_latency: got %0d want 33", lat); end
      n_cmp++; if (duck_hit !== 4'b1001) begin n_err++; $display("FAIL bound_duck_hit: got %b want 1001", duck_hit); end
      n_cmp++; if (shot_kill !== 8'h11) begin n_err++; $display("FAIL bound_shot_kill: got %h want 11", shot_kill); end
      n_cmp++; if (score !== 10'(exp_score)) begin n_err++; $display("FAIL bound_score: got %0d want %0d", score, exp_score); end
   endtask

   task automatic test_overrun();
      int first, pulses;
      logic ov6, busy34;
      logic [3:0] hit_at;
      // Second frame_start in the middle of a scan
      clear_inputs();
      set_duck(0, 100, 50, 1'b1);
      set_shot(3, 120, 60, 1'b1);
      start_frame();
      first = -1; pulses = 0; ov6 = 1'b0; hit_at = '0;
      for (int i = 1; i <= 45; i++) begin
         @(posedge clk); #1;
         if (done) begin pulses++; if (first < 0) begin first = i; hit_at = duck_hit; end end
         if (i == 4) frame_start = 1'b1;
         if (i == 5) frame_start = 1'b0;
         if (i == 6) ov6 = overrun;
      end
      exp_score += 1;
      n_cmp++; if (ov6 !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b want 1", ov6); end
      n_cmp++; if (first !== 33 || pulses !== 1) begin n_err++; $display("FAIL overrun_scan: got done@%0d x%0d want done@33 x1", first, pulses); end
      n_cmp++; if (hit_at !== 4'b0001) begin n_err++; $display("FAIL overrun_hit: got %b want 0001", hit_at); end
      n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
      n_cmp++; if (score !== 10'(exp_score)) begin n_err++; $display("FAIL overrun_score: got %0d want %0d", score, exp_score); end
      // Reset clears it; frame_start landing on COMMIT is ignored too
      reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
      exp_score = 0;
      n_cmp++; if ({overrun, score} !== 11'd0) begin n_err++; $display("FAIL overrun_reset: got %b/%0d want 0/0", overrun, score); end
      start_frame();
      first = -1; pulses = 0; busy34 = 1'b1;
      for (int i = 1; i <= 75; i++) begin
         @(posedge clk); #1;
         if (done) begin pulses++; if (first < 0) first = i; end
         if (i == 32) frame_start = 1'b1;
         if (i == 33) frame_start = 1'b0;
         if (i == 34) busy34 = busy;
      end
      exp_score += 1;
      n_cmp++; if (first !== 33 || pulses !== 1) begin n_err++; $display("FAIL commit_ignore: got done@%0d x%0d want done@33 x1", first, pulses); end
      n_cmp++; if ({overrun, busy34} !== 2'b10) begin n_err++; $display("FAIL commit_overrun: got %b want 10", {overrun, busy34}); end
      n_cmp++; if (score !== 10'(exp_score)) begin n_err++; $display("FAIL commit_score: got %0d want %0d", score, exp_score); end
   endtask

   task automatic test_snapshot();
      int lat;
      clear_inputs();
      set_duck(0, 100, 50, 1'b1);
      set_shot(3, 120, 60, 1'b1);
      start_frame();
      set_shot(3, 600, 400, 1'b0);  // changes after the snapshot are invisible
      set_duck(0, 700, 0, 1'b0);
      wait_done(lat);
      exp_score += 1;
      n_cmp++; if ({duck_hit, shot_kill} !== {4'b0001, 8'h08}) begin n_err++; $display("FAIL snapshot_hit: got %b/%h want 0001/08", duck_hit, shot_kill); end
      n_cmp++; if (score !== 10'(exp_score)) begin n_err++; $display("FAIL snapshot_score: got %0d want %0d", score, exp_score); end
      // No valid shots: still commits with empty masks
      clear_inputs();
      for (int d = 0; d < 4; d++) set_duck(d, 100, 50, 1'b1);
      set_shot(3, 120, 60, 1'b0);
      start_frame(); wait_done(lat);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL noshot_done: got %0d want 33", lat); end
      n_cmp++; if ({duck_hit, shot_kill} !== 12'h000) begin n_err++; $display("FAIL noshot_masks: got %h want 000", {duck_hit, shot_kill}); end
      n_cmp++; if (score !== 10'(exp_score)) begin n_err++; $display("FAIL noshot_score: got %0d want %0d", score, exp_score); end
   endtask

   task automatic test_saturation();
      int lat;
      int want;
      reset_sat = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (score_s !== 4'd0) begin n_err++; $display("FAIL sat_reset: got %0d want 0", score_s); end
      clear_inputs();
      set_duck(0, 100, 50, 1'b1);
      set_duck(1, 300, 50, 1'b1);
      set_shot(0, 120, 60, 1'b1);
      set_shot(1, 320, 60, 1'b1);
      // Two hits per frame: 2,4,...,14 then pinned at 15
      for (int f = 1; f <= 9; f++) begin
         start_frame_sat(); wait_done_sat(lat);
         want = (2 * f > 15) ? 15 : 2 * f;
         n_cmp++; if (lat !== 33 || score_s !== 4'(want)) begin n_err++; $display("FAIL sat_frame%0d: got %0d (done@%0d) want %0d (done@33)", f, score_s, lat, want); end
      end
   endtask

   initial begin
      reset = 1'b1; reset_sat = 1'b1;
      frame_start = 1'b0; frame_start_sat = 1'b0;
      clear_inputs();
      test_reset();
      test_single_hit();
      test_arbitration();
      test_boundaries();
      test_overrun();
      test_snapshot();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
